// File: rtl/pixel_grid_pool.sv
// Binary-mask downsampler: pools a raster stream of 1-bit pixels into a grid of
// cells, emitting one decision bit plus the set-pixel count per completed cell.
module pixel_grid_pool #(
    parameter int CELL_W = 10,
    parameter int CELL_H = 10,
    parameter int GRID_W = 32,
    parameter int GRID_H = 24,
    parameter int CNT_W  = $clog2(CELL_W*CELL_H+1)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [10:0]               hcount_in,
    input  logic [9:0]                vcount_in,
    input  logic                      data_valid_in,
    input  logic                      pixel_in,
    input  logic [1:0]                mode_in,
    input  logic [CNT_W-1:0]          thresh_in,
    output logic                      pixel_out,
    output logic [CNT_W-1:0]          count_out,
    output logic [$clog2(GRID_W)-1:0] hcount_out,
    output logic [$clog2(GRID_H)-1:0] vcount_out,
    output logic                      data_valid_out
);

    localparam int CX_W  = $clog2(GRID_W);
    localparam int CY_W  = $clog2(GRID_H);
    localparam int SX_W  = $clog2(CELL_W);
    localparam int SY_W  = $clog2(CELL_H);
    localparam int ACT_W = GRID_W * CELL_W;
    localparam int ACT_H = GRID_H * CELL_H;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] MODE_CENTRE = 2'd0;
    localparam logic [1:0] MODE_ANY    = 2'd2;

    localparam logic [SX_W-1:0] SX_CENTRE = SX_W'(CELL_W / 2);
    localparam logic [SY_W-1:0] SY_CENTRE = SY_W'(CELL_H / 2);
    localparam logic [SX_W-1:0] SX_LAST   = SX_W'(CELL_W - 1);
    localparam logic [SY_W-1:0] SY_LAST   = SY_W'(CELL_H - 1);

    // Input decode: active-area test and constant divide/modulo
    logic            in_active;
    logic [CX_W-1:0] cx_d;
    logic [CY_W-1:0] cy_d;
    logic [SX_W-1:0] sx_d;
    logic [SY_W-1:0] sy_d;

    assign in_active = data_valid_in
                       && (32'(hcount_in) < ACT_W)
                       && (32'(vcount_in) < ACT_H);
    assign cx_d = CX_W'(hcount_in / 11'(CELL_W));
    assign sx_d = SX_W'(hcount_in % 11'(CELL_W));
    assign cy_d = CY_W'(vcount_in / 10'(CELL_H));
    assign sy_d = SY_W'(vcount_in % 10'(CELL_H));

    logic            s1_valid;
    logic            s1_pixel;
    logic [CX_W-1:0] s1_cx;
    logic [CY_W-1:0] s1_cy;
    logic [SX_W-1:0] s1_sx;
    logic [SY_W-1:0] s1_sy;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            s1_valid <= 1'b0;
            s1_pixel <= 1'b0;
            s1_cx    <= '0;
            s1_cy    <= '0;
            s1_sx    <= '0;
            s1_sy    <= '0;
        end else begin
            s1_valid <= in_active;
            s1_pixel <= pixel_in;
            s1_cx    <= cx_d;
            s1_cy    <= cy_d;
            s1_sx    <= sx_d;
            s1_sy    <= sy_d;
        end
    end

    // One accumulator and one centre bit per cell column; each cell row reuses them
    logic [CNT_W-1:0]  acc [GRID_W];
    logic [GRID_W-1:0] ctr;

    logic [CNT_W-1:0] acc_rd;
    logic [CNT_W:0]   sum_ext;
    logic [CNT_W-1:0] acc_sum;
    logic             is_first;
    logic             is_centre;
    logic             is_last;
    logic             centre_bit;
    logic             decision;

    always_comb begin
        acc_rd     = acc[s1_cx];
        sum_ext    = {1'b0, acc_rd} + (CNT_W+1)'(s1_pixel);
        acc_sum    = sum_ext[CNT_W] ? CNT_MAX : sum_ext[CNT_W-1:0];
        is_first   = (s1_sx == '0) && (s1_sy == '0);
        is_centre  = (s1_sx == SX_CENTRE) && (s1_sy == SY_CENTRE);
        is_last    = (s1_sx == SX_LAST) && (s1_sy == SY_LAST);
        centre_bit = is_centre ? s1_pixel : ctr[s1_cx];
        case (mode_in)
            MODE_CENTRE: decision = centre_bit;
            MODE_ANY:    decision = (acc_sum != '0);
            default:     decision = (acc_sum >= thresh_in);
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < GRID_W; i++) begin
                acc[i] <= '0;
            end
            ctr            <= '0;
            pixel_out      <= 1'b0;
            count_out      <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            if (s1_valid) begin
                // First pixel of a cell reloads, which clears the previous cell's total
                acc[s1_cx] <= is_first ? CNT_W'(s1_pixel) : acc_sum;
                if (is_centre) begin
                    ctr[s1_cx] <= s1_pixel;
                end
                if (is_last) begin
                    count_out      <= acc_sum;
                    hcount_out     <= s1_cx;
                    vcount_out     <= s1_cy;
                    pixel_out      <= decision;
                    data_valid_out <= 1'b1;
                end
            end
        end
    end

endmodule
